// File: rtl/uart_rx_if.sv
// Received-byte bus: byte, one-cycle valid strobe and one-cycle frame-error strobe.
interface uart_rx_if;
    logic [7:0] data_dat;
    logic       data_vld;
    logic       frame_err;

    modport master (output data_dat, output data_vld, output frame_err);
    modport slave  (input  data_dat, input  data_vld, input  frame_err);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver sampling each bit at mid-bit; valid/frame-error pulse ~2+H+9*bit cycles after start edge.
// No backpressure: each byte is presented for exactly one cycle and held until the next good frame.
module uart_rx #(
    parameter int unsigned c_CYCLES_PER_BIT = 217
) (
    input  logic      i_CLK,
    input  logic      i_RESET,
    input  logic      serial_i,
    uart_rx_if.master rx_o
);

    localparam logic [15:0] LAST = 16'(c_CYCLES_PER_BIT - 1);
    localparam logic [15:0] HALF = 16'((c_CYCLES_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_t;

    state_t      state_q;
    logic        sync1_q, sync2_q;
    logic [15:0] cnt_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shreg_q;
    logic [7:0]  data_q;
    logic        vld_q;
    logic        ferr_q;
    logic        rx_s;

    // Synchronizer resets to the idle (high) line level.
    always_ff @(posedge i_CLK or negedge i_RESET) begin
        if (!i_RESET) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= serial_i;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    always_ff @(posedge i_CLK or negedge i_RESET) begin
        if (!i_RESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            vld_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            vld_q  <= 1'b0;
            ferr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q     <= '0;
                    bit_idx_q <= '0;
                    if (!rx_s) state_q <= START;
                end
                START: begin
                    if (cnt_q == HALF) begin
                        cnt_q   <= '0;
                        state_q <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                DATA: begin
                    if (cnt_q == LAST) begin
                        cnt_q              <= '0;
                        shreg_q[bit_idx_q] <= rx_s;
                        if (bit_idx_q == 3'd7) state_q <= STOP;
                        else                   bit_idx_q <= bit_idx_q + 3'd1;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                STOP: begin
                    if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        state_q <= CLEANUP;
                        if (rx_s) begin
                            data_q <= shreg_q;
                            vld_q  <= 1'b1;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                // A break or stuck-low line must go high before another start is accepted.
                CLEANUP: begin
                    cnt_q     <= '0;
                    bit_idx_q <= '0;
                    if (rx_s) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_o.data_dat  = data_q;
    assign rx_o.data_vld  = vld_q;
    assign rx_o.frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame-level model predicts each pulse, its byte and its timing window.
module tb_uart_rx;
    localparam int CPB  = 217;
    localparam int HALF = (CPB - 1) / 2;
    localparam int TOL  = 3;

    typedef struct {
        bit         is_err;
        logic [7:0] dat;
        int         exp_cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    logic serial;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   nvld = 0;
    int   nferr = 0;
    logic [7:0] last_good;
    ev_t  exp_q[$];
    ev_t  e;

    uart_rx_if rx_if ();

    uart_rx #(.c_CYCLES_PER_BIT(CPB)) dut (
        .i_CLK    (clk),
        .i_RESET  (rst_n),
        .serial_i (serial),
        .rx_o     (rx_if)
    );

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start edge is driven at a negedge; the frame's pulse is predicted from that cycle.
    task automatic send_frame(input logic [7:0] b, input bit stop_hi, input int stretch);
        ev_t ev;
        ev.is_err  = !stop_hi;
        ev.dat     = b;
        ev.exp_cyc = cyc + 3 + HALF + 9 * CPB;
        exp_q.push_back(ev);
        serial = 1'b0;
        idle(CPB + stretch);
        for (int i = 0; i < 8; i++) begin
            serial = b[i];
            idle(CPB);
        end
        serial = stop_hi;
        idle(CPB);
        serial = 1'b1;
    endtask

    always @(negedge clk) begin
        check("vld_ferr_exclusive", {31'd0, rx_if.data_vld & rx_if.frame_err}, 32'd0);
        if (rx_if.data_vld || rx_if.frame_err) begin
            if (rx_if.data_vld) nvld++;
            if (rx_if.frame_err) nferr++;
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {31'd0, rx_if.data_vld | rx_if.frame_err}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", {31'd0, rx_if.frame_err}, {31'd0, e.is_err});
                check("pulse_time", {31'd0, (cyc >= e.exp_cyc - TOL) && (cyc <= e.exp_cyc + TOL)}, 32'd1);
                if (rx_if.data_vld && !e.is_err) last_good = e.dat;
            end
        end else if (exp_q.size() != 0 && cyc > exp_q[0].exp_cyc + TOL) begin
            check("pulse_missing", 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end
        check("data_hold", {24'd0, rx_if.data_dat}, {24'd0, last_good});
    end

    initial begin
        int v0, f0;
        serial    = 1'b1;
        rst_n     = 1'b0;
        last_good = 8'h00;
        idle(5);
        check("rst_dat", {24'd0, rx_if.data_dat}, 32'h00);
        check("rst_vld", {31'd0, rx_if.data_vld}, 32'd0);
        check("rst_ferr", {31'd0, rx_if.frame_err}, 32'd0);
        rst_n = 1'b1;
        idle(2 * CPB);

        // 1: basic frame
        v0 = nvld; f0 = nferr;
        send_frame(8'h1A, 1'b1, 0);
        idle(2 * CPB);
        check("t1_dat", {24'd0, rx_if.data_dat}, 32'h1A);
        check("t1_nvld", nvld - v0, 1);
        check("t1_nferr", nferr - f0, 0);

        // 2: start bit stretched by 25 cycles
        v0 = nvld;
        send_frame(8'h1A, 1'b1, 25);
        idle(2 * CPB);
        check("t2_dat", {24'd0, rx_if.data_dat}, 32'h1A);
        check("t2_nvld", nvld - v0, 1);

        // 3: back-to-back frames, no idle gap
        v0 = nvld;
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        send_frame(8'hA5, 1'b1, 0);
        idle(2 * CPB);
        check("t3_dat", {24'd0, rx_if.data_dat}, 32'hA5);
        check("t3_nvld", nvld - v0, 3);

        // 4: short low glitch then a real frame
        v0 = nvld; f0 = nferr;
        serial = 1'b0;
        idle(50);
        serial = 1'b1;
        idle(2 * CPB);
        check("t4_glitch_nvld", nvld - v0, 0);
        check("t4_glitch_nferr", nferr - f0, 0);
        send_frame(8'h3C, 1'b1, 0);
        idle(2 * CPB);
        check("t4_dat", {24'd0, rx_if.data_dat}, 32'h3C);

        // 5: stop bit low
        v0 = nvld; f0 = nferr;
        send_frame(8'h55, 1'b0, 0);
        idle(2 * CPB);
        check("t5_nferr", nferr - f0, 1);
        check("t5_nvld", nvld - v0, 0);
        check("t5_dat_kept", {24'd0, rx_if.data_dat}, 32'h3C);
        send_frame(8'h81, 1'b1, 0);
        idle(2 * CPB);
        check("t5_next_dat", {24'd0, rx_if.data_dat}, 32'h81);

        // 6: reset during data bit 4 of a partial 0x99 frame
        v0 = nvld; f0 = nferr;
        serial = 1'b0;
        idle(CPB);
        for (int i = 0; i < 4; i++) begin
            serial = (i == 0 || i == 3);
            idle(CPB);
        end
        serial = 1'b1;
        idle(100);
        @(posedge clk);
        #5;
        rst_n     = 1'b0;
        last_good = 8'h00;
        serial    = 1'b1;
        idle(10);
        check("t6_rst_dat", {24'd0, rx_if.data_dat}, 32'h00);
        rst_n = 1'b1;
        idle(2 * CPB);
        check("t6_nvld", nvld - v0, 0);
        check("t6_nferr", nferr - f0, 0);
        check("t6_dat", {24'd0, rx_if.data_dat}, 32'h00);
        send_frame(8'h7E, 1'b1, 0);
        idle(2 * CPB);
        check("t6_next_dat", {24'd0, rx_if.data_dat}, 32'h7E);

        check("pending_events", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
